// File: rtl/scemi_pipe_pkg.sv
// Shared definitions for SCE-MI output pipes: header beat layout, FSM states, message cost.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scemi_pipe_pkg;

  localparam int HDR_W  = 32;  // link beat / header width
  localparam int CRED_W = 17;  // credit counter width (saturating)

  // Header beat: [31:24] pipe id, [23] end-of-message, [22:8] zero, [7:0] element count
  localparam int HDR_ID_LSB  = 24;
  localparam int HDR_EOM_BIT = 23;
  localparam int HDR_CNT_LSB = 0;

  typedef struct packed {
    logic [7:0]  pipe_id;
    logic        eom;
    logic [14:0] rsvd;
    logic [7:0]  count;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } xmit_state_t;

  // Beats consumed by one message: the header plus every payload beat.
  function automatic logic [31:0] msg_cost(input logic [7:0] count, input int bpe);
    return 32'(1 + int'(count) * bpe);
  endfunction

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scemi_pipe_fifo.sv
// Synchronous WIDTH x DEPTH FIFO with registered occupancy; head word visible on rd_data.
// Latency: a write is visible in occ and at the head one cycle after it is accepted.
// Backpressure: full_n follows registered occ; writes while full are dropped, reads while empty ignored.
//
// Ports: CLK/RST clock and async active-high reset; enq/wr_data write side;
//        deq/rd_data read side (head word); occ entry count; full_n not-full flag.
module scemi_pipe_fifo
  import scemi_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enq,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  deq,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ptr_w(DEPTH):0] occ,
  output logic                  full_n
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_enq;
  logic             do_deq;

  assign full_n  = (occ != (PW+1)'(DEPTH));
  assign do_enq  = enq && full_n;
  assign do_deq  = deq && (occ != '0);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: only entries covered by occ are ever read.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_enq) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/scemi_outpipe_xmit.sv
// SCE-MI output pipe producer: buffers DUT elements and frames them as header + payload beats on the link.
// Latency: element enqueued at t is in occ at t+1; earliest header beat at t+2.
// Backpressure: FULL_N throttles the DUT; beats held stable until BEAT_READY; launches gated by host credits.
//
// Ports: CLK, RST (async active-high); ENQ/D_IN/FULL_N element input; FLUSH end-of-message request;
//        CREDIT_VLD/CREDIT_AMT host beat grants; BEAT_VALID/BEAT_DATA/BEAT_READY 32-bit link output.
module scemi_outpipe_xmit
  import scemi_pipe_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 16,
  parameter int         MAX_BURST = 8,
  parameter logic [7:0] PIPE_ID   = 8'd0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic [WIDTH-1:0] D_IN,
  output logic             FULL_N,
  input  logic             FLUSH,
  input  logic             CREDIT_VLD,
  input  logic [15:0]      CREDIT_AMT,
  output logic             BEAT_VALID,
  output logic [31:0]      BEAT_DATA,
  input  logic             BEAT_READY
);

  localparam int         BPE      = (WIDTH + HDR_W - 1) / HDR_W;
  localparam int         PAD_W    = BPE * HDR_W;
  localparam int         BIW      = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int         OCC_W    = ptr_w(DEPTH) + 1;
  localparam logic [31:0] MB32     = 32'(MAX_BURST);
  localparam logic [31:0] CRED_MAX = 32'((1 << CRED_W) - 1);

  xmit_state_t       st;
  xmit_state_t       st_n;
  logic [CRED_W-1:0] credits;
  logic [CRED_W-1:0] credits_n;
  logic              flush_pend;
  logic              msg_eom;
  logic [7:0]        msg_cnt;
  logic [7:0]        elem_cnt;
  logic [BIW-1:0]    beat_idx;

  logic [OCC_W-1:0]  occ;
  logic [WIDTH-1:0]  head;
  logic [PAD_W-1:0]  head_pad;
  logic [31:0]       occ32;
  logic [31:0]       cost;
  logic [31:0]       avail;
  logic [31:0]       cred_sum;
  logic              trig;
  logic              launch;
  logic              launch_eom;
  logic [7:0]        launch_cnt;
  logic              last_beat;
  logic              elem_done;
  logic              msg_done;
  hdr_t              hdr;

  scemi_pipe_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .enq     (ENQ),
    .wr_data (D_IN),
    .deq     (elem_done),
    .rd_data (head),
    .occ     (occ),
    .full_n  (FULL_N)
  );

  // Launch decision. A grant arriving this cycle counts towards the check so the
  // header can follow the grant by one cycle; the whole message cost is reserved
  // at launch, so once started a message never waits on credit.
  always_comb begin
    occ32      = 32'(occ);
    trig       = (occ32 >= MB32) || flush_pend;
    launch_cnt = (occ32 >= MB32) ? 8'(MAX_BURST) : 8'(occ);
    launch_eom = flush_pend && (occ32 <= MB32);
    cost       = msg_cost(launch_cnt, BPE);
    avail      = 32'(credits) + (CREDIT_VLD ? 32'(CREDIT_AMT) : 32'd0);
    launch     = (st == ST_IDLE) && trig && (avail >= cost);
    cred_sum   = avail - (launch ? cost : 32'd0);
    credits_n  = (cred_sum > CRED_MAX) ? CRED_MAX[CRED_W-1:0] : cred_sum[CRED_W-1:0];
  end

  always_comb begin
    hdr         = '0;
    hdr.pipe_id = PIPE_ID;
    hdr.eom     = msg_eom;
    hdr.count   = msg_cnt;
    head_pad               = '0;
    head_pad[WIDTH-1:0]    = head;
  end

  assign last_beat = (beat_idx == BIW'(BPE - 1));
  assign elem_done = (st == ST_DATA) && BEAT_READY && last_beat;
  assign msg_done  = elem_done && (elem_cnt == msg_cnt - 8'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st <= ST_IDLE;
    else     st <= st_n;
  end

  always_comb begin
    st_n       = st;
    BEAT_VALID = 1'b0;
    BEAT_DATA  = '0;
    case (st)
      ST_IDLE: begin
        if (launch) st_n = ST_HDR;
      end
      ST_HDR: begin
        BEAT_VALID = 1'b1;
        BEAT_DATA  = hdr;
        if (BEAT_READY) st_n = (msg_cnt == 8'd0) ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        // Least-significant word of the head element first; the head only
        // advances after its last beat transfers, so data holds while stalled.
        BEAT_VALID = 1'b1;
        BEAT_DATA  = head_pad[HDR_W*int'(beat_idx) +: HDR_W];
        if (msg_done) st_n = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credits    <= '0;
      flush_pend <= 1'b0;
      msg_cnt    <= '0;
      msg_eom    <= 1'b0;
      elem_cnt   <= '0;
      beat_idx   <= '0;
    end else begin
      credits <= credits_n;
      // A flush that cannot be fully honoured by this launch (more than a burst
      // buffered) stays pending; a new pulse always wins over the clear.
      flush_pend <= (flush_pend && !(launch && launch_eom)) || FLUSH;
      if (launch) begin
        msg_cnt  <= launch_cnt;
        msg_eom  <= launch_eom;
        elem_cnt <= '0;
        beat_idx <= '0;
      end else if ((st == ST_DATA) && BEAT_READY) begin
        if (last_beat) begin
          beat_idx <= '0;
          elem_cnt <= elem_cnt + 8'd1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scemi_outpipe_xmit.sv
`timescale 1ns/1ps
module tb_scemi_outpipe_xmit;

  localparam int         W   = 40;
  localparam int         DEP = 8;
  localparam int         MB  = 4;
  localparam int         BPE = (W + 31) / 32;
  localparam logic [7:0] PID = 8'h5A;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ENQ;
  logic [W-1:0]  D_IN;
  logic          FULL_N;
  logic          FLUSH;
  logic          CREDIT_VLD;
  logic [15:0]   CREDIT_AMT;
  logic          BEAT_VALID;
  logic [31:0]   BEAT_DATA;
  logic          BEAT_READY;

  int tests = 0;
  int fails = 0;

  // Reference model, message level:
  //   exp_q    payload words of accepted elements, in link order
  //   pend     accepted elements not yet announced by a header
  //   flush_req flush requested and not yet closed by an EOM header
  //   cred     host credits granted minus beats the DUT has committed
  //   pay_left payload beats still owed by the current message
  logic [31:0] exp_q[$];
  int pend = 0;
  bit flush_req = 0;
  int cred = 0;
  int pay_left = 0;

  always #5 CLK = ~CLK;

  scemi_outpipe_xmit #(
    .WIDTH     (W),
    .DEPTH     (DEP),
    .MAX_BURST (MB),
    .PIPE_ID   (PID)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENQ        (ENQ),
    .D_IN       (D_IN),
    .FULL_N     (FULL_N),
    .FLUSH      (FLUSH),
    .CREDIT_VLD (CREDIT_VLD),
    .CREDIT_AMT (CREDIT_AMT),
    .BEAT_VALID (BEAT_VALID),
    .BEAT_DATA  (BEAT_DATA),
    .BEAT_READY (BEAT_READY)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic enq_elem(input logic [W-1:0] v);
    logic [BPE*32-1:0] p;
    p = '0;
    p[W-1:0] = v;
    ENQ  = 1'b1;
    D_IN = v;
    if (FULL_N === 1'b1) begin
      for (int b = 0; b < BPE; b++) exp_q.push_back(p[32*b +: 32]);
      pend++;
    end
    tick(1);
    ENQ = 1'b0;
  endtask

  task automatic grant(input int amt);
    CREDIT_VLD = 1'b1;
    CREDIT_AMT = 16'(amt);
    cred += amt;
    tick(1);
    CREDIT_VLD = 1'b0;
    CREDIT_AMT = '0;
  endtask

  task automatic flush_pulse();
    FLUSH = 1'b1;
    flush_req = 1'b1;
    tick(1);
    FLUSH = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(pay_left == 0 && !flush_req && pend < MB && BEAT_VALID === 1'b0) && n < 3000) begin
      tick(1);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s: drain timeout, pend=%0d pay_left=%0d flush_req=%0d, required idle link",
               nm, pend, pay_left, flush_req);
    end
    tick(3);
  endtask

  // Link ready toggles randomly for the whole run.
  initial begin
    BEAT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      BEAT_READY = ($urandom_range(3) != 0);
    end
  end

  // Monitor: samples the link at the falling edge, commits a transfer at the
  // following rising edge unless reset intervened.
  initial begin : monitor
    logic v, r, pv, pr, eom;
    logic [31:0] d, pd;
    int cnt, cost;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge CLK);
      v = BEAT_VALID;
      r = BEAT_READY;
      d = BEAT_DATA;
      if (RST === 1'b0 && pv && !pr)
        check("stall_hold", 64'({v, d}), 64'({1'b1, pd}));
      pv = v && (RST === 1'b0);
      pr = r;
      pd = d;
      @(posedge CLK);
      if (RST === 1'b1) begin
        pv = 1'b0;
      end else if (v && r) begin
        if (pay_left == 0) begin
          if (flush_req) begin
            cnt = (pend < MB) ? pend : MB;
            eom = (pend <= MB);
            if (eom) flush_req = 1'b0;
          end else begin
            check("hdr_trigger", 64'(pend >= MB), 64'd1);
            cnt = MB;
            eom = 1'b0;
          end
          check("header", 64'(d), 64'({PID, eom, 15'd0, 8'(cnt)}));
          cost = 1 + cnt * BPE;
          check("credit_cover", 64'(cred >= cost), 64'd1);
          cred -= cost;
          pend -= cnt;
          pay_left = cnt * BPE;
        end else begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL payload_extra: got %h expected no beat", d);
          end else begin
            check("payload", 64'(d), 64'(exp_q.pop_front()));
          end
          pay_left--;
        end
      end
    end
  end

  initial begin
    logic [63:0] rv;
    int n;
    RST = 1'b0; ENQ = 1'b0; D_IN = '0; FLUSH = 1'b0; CREDIT_VLD = 1'b0; CREDIT_AMT = '0;
    #1 RST = 1'b1;
    #1;
    check("rst_full_n", 64'(FULL_N), 64'd1);
    check("rst_valid", 64'(BEAT_VALID), 64'd0);
    check("rst_data", 64'(BEAT_DATA), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick(1);

    // Full burst, exact credit: header COUNT=4 then two beats per element.
    enq_elem(40'h11_AAAA_0001);
    enq_elem(40'h22_BBBB_0002);
    enq_elem(40'h33_CCCC_0003);
    enq_elem(40'h44_DDDD_0004);
    grant(1 + MB * BPE);
    wait_idle("burst4");

    // Trigger met but credit short: silent until the top-up grant.
    for (int i = 0; i < MB; i++) enq_elem(40'(i + 16'hE0));
    grant(2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (BEAT_VALID !== 1'b0) n++;
      tick(1);
    end
    check("no_launch_short_credit", 64'(n), 64'd0);
    grant(1 + MB * BPE - 2);
    check("hdr_after_grant", 64'(BEAT_VALID), 64'd1);
    wait_idle("credit_wait");

    // Single wide element closed by a flush.
    enq_elem(40'hAB_1234_5678);
    tick(2);
    flush_pulse();
    tick(2);
    grant(3);
    wait_idle("flush_one");

    // Flush with an empty FIFO: header-only EOM message.
    flush_pulse();
    grant(1);
    wait_idle("flush_empty");

    // Fill to capacity with no credit; one extra write must be dropped.
    for (int i = 0; i < DEP; i++) enq_elem(40'(32'hF000_0000 + i));
    check("full_n_low", 64'(FULL_N), 64'd0);
    enq_elem(40'hDE_AD00_BEEF);
    grant(2 * (1 + MB * BPE));
    wait_idle("fill_drain");

    // Reset in the middle of a message.
    for (int i = 0; i < MB; i++) enq_elem(40'(32'hC000_0000 + i));
    grant(1 + MB * BPE);
    n = 0;
    while (pay_left != 2 * BPE && n < 500) begin
      tick(1);
      n++;
    end
    check("mid_msg_reached", 64'(n < 500), 64'd1);
    #1 RST = 1'b1;
    #1;
    check("rst_mid_valid", 64'(BEAT_VALID), 64'd0);
    check("rst_mid_full_n", 64'(FULL_N), 64'd1);
    exp_q.delete();
    pend = 0; flush_req = 1'b0; cred = 0; pay_left = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick(1);
    enq_elem(40'h5C_0BAD_F00D);
    tick(2);
    flush_pulse();
    grant(3);
    wait_idle("after_reset");

    // Random traffic, random grants.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(3))
        0, 1: begin
          if (FULL_N === 1'b1) begin
            rv = {$urandom(), $urandom()};
            enq_elem(rv[W-1:0]);
          end else begin
            tick(1);
          end
        end
        2:       grant($urandom_range(10));
        default: tick(1);
      endcase
    end
    grant(300);
    wait_idle("random_drain");
    flush_pulse();
    grant(1 + MB * BPE);
    wait_idle("random_flush");
    check("end_payload_left", 64'(exp_q.size()), 64'd0);
    check("end_pend", 64'(pend), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
